// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types for the register-file write-port arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // Which source drives the write port in the current cycle
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_PIPE = 2'd1,
    WB_MDU  = 2'd2
  } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Issue, writeback, MDU result and register-file write signals
//               of the write-port arbiter. The master side is the surrounding
//               core (issue stage, writeback, MDU, register file); the slave
//               side is the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if;
  import wb_pkg::*;

  logic      issue_valid_i;
  reg_addr_t issue_rs_i;
  reg_addr_t issue_rt_i;
  reg_addr_t issue_rd_i;
  logic      issue_long_i;
  logic      issue_stall_o;

  logic      pipe_we_i;
  reg_addr_t pipe_wa_i;
  word_t     pipe_wd_i;

  logic      mdu_valid_i;
  reg_addr_t mdu_wa_i;
  word_t     mdu_wd_i;
  logic      mdu_ready_o;

  logic      pipe_hold_o;

  logic      we3_o;
  reg_addr_t wa3_o;
  word_t     wd3_o;

  modport master (
    output issue_valid_i, issue_rs_i, issue_rt_i, issue_rd_i, issue_long_i,
    output pipe_we_i, pipe_wa_i, pipe_wd_i,
    output mdu_valid_i, mdu_wa_i, mdu_wd_i,
    input  issue_stall_o, mdu_ready_o, pipe_hold_o,
    input  we3_o, wa3_o, wd3_o
  );

  modport slave (
    input  issue_valid_i, issue_rs_i, issue_rt_i, issue_rd_i, issue_long_i,
    input  pipe_we_i, pipe_wa_i, pipe_wd_i,
    input  mdu_valid_i, mdu_wa_i, mdu_wd_i,
    output issue_stall_o, mdu_ready_o, pipe_hold_o,
    output we3_o, wa3_o, wd3_o
  );

endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Busy bits for registers awaiting an MDU result, plus a count
//               of MDU operations in flight. Answers the issue hazard query.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
  import wb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  // hazard query from issue
  input  logic      query_valid_i,
  input  logic      query_long_i,
  input  reg_addr_t query_rs_i,
  input  reg_addr_t query_rt_i,
  input  reg_addr_t query_rd_i,
  output logic      hazard_o,
  // accepted long issue: marks destination busy, counts one more in flight
  input  logic      alloc_i,
  input  reg_addr_t alloc_addr_i,
  // granted MDU result: frees its register, counts one fewer in flight
  input  logic      release_i,
  input  reg_addr_t release_addr_i
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] c_max_out = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]      r_busy;
  logic [31:0]      w_busy_nxt;
  logic [CNT_W-1:0] r_outstanding;
  logic             w_dec;

  // Clear first so a same-address set in the same cycle wins; r0 never busy
  always_comb begin
    w_busy_nxt = r_busy;
    if (release_i) w_busy_nxt[release_addr_i] = 1'b0;
    if (alloc_i)   w_busy_nxt[alloc_addr_i]   = 1'b1;
    w_busy_nxt[REG_ZERO] = 1'b0;
  end

  // A stray result with nothing in flight must not wrap the counter
  assign w_dec = release_i && (r_outstanding != '0);

  // Busy vector and in-flight counter state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy        <= '0;
      r_outstanding <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      case ({alloc_i, w_dec})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign hazard_o = query_valid_i &&
                    (r_busy[query_rs_i] || r_busy[query_rt_i] || r_busy[query_rd_i] ||
                     (query_long_i && (r_outstanding == c_max_out)));

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the register-file write port between pipeline
//               writeback and the MDU, with a starvation hold that gives the
//               MDU a bounded wait, and stalls issue on MDU register hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT    = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_port_arbiter_if.slave  bus
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] c_wait_limit = WAIT_W'(STARVE_LIMIT);

  logic              w_pipe_req;
  logic              w_mdu_ready;
  logic              w_mdu_grant;
  logic              w_hazard;
  logic              w_long_accept;
  logic              r_pipe_hold;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  wb_src_e           w_src;

  reg_scoreboard #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_scoreboard (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .query_valid_i  (bus.issue_valid_i),
    .query_long_i   (bus.issue_long_i),
    .query_rs_i     (bus.issue_rs_i),
    .query_rt_i     (bus.issue_rt_i),
    .query_rd_i     (bus.issue_rd_i),
    .hazard_o       (w_hazard),
    .alloc_i        (w_long_accept),
    .alloc_addr_i   (bus.issue_rd_i),
    .release_i      (w_mdu_grant),
    .release_addr_i (bus.mdu_wa_i)
  );

  // Writes to r0 are not real requests, so they never block the MDU
  assign w_pipe_req    = bus.pipe_we_i && (bus.pipe_wa_i != REG_ZERO);
  assign w_mdu_ready   = !w_pipe_req || r_pipe_hold;
  assign w_mdu_grant   = bus.mdu_valid_i && w_mdu_ready;
  assign w_long_accept = bus.issue_valid_i && !w_hazard && bus.issue_long_i;

  // Grant select: pipeline first unless held; r0 MDU results are swallowed
  always_comb begin
    w_src = WB_NONE;
    if (w_pipe_req && !r_pipe_hold)                  w_src = WB_PIPE;
    else if (w_mdu_grant && bus.mdu_wa_i != REG_ZERO) w_src = WB_MDU;
  end

  // Write port mux, zeroed when idle
  always_comb begin
    bus.we3_o = 1'b0;
    bus.wa3_o = REG_ZERO;
    bus.wd3_o = '0;
    case (w_src)
      WB_PIPE: begin
        bus.we3_o = 1'b1;
        bus.wa3_o = bus.pipe_wa_i;
        bus.wd3_o = bus.pipe_wd_i;
      end
      WB_MDU: begin
        bus.we3_o = 1'b1;
        bus.wa3_o = bus.mdu_wa_i;
        bus.wd3_o = bus.mdu_wd_i;
      end
      default: ;
    endcase
  end

  // Count consecutive refused MDU cycles; saturate at the limit
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!bus.mdu_valid_i || w_mdu_grant)  w_wait_nxt = '0;
    else if (r_wait_cnt != c_wait_limit)  w_wait_nxt = r_wait_cnt + 1'b1;
  end

  // Starvation state: the hold is raised the cycle after the limit is hit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wait_cnt  <= '0;
      r_pipe_hold <= 1'b0;
    end else begin
      r_wait_cnt  <= w_wait_nxt;
      r_pipe_hold <= (w_wait_nxt == c_wait_limit);
    end
  end

  assign bus.mdu_ready_o   = w_mdu_ready;
  assign bus.pipe_hold_o   = r_pipe_hold;
  assign bus.issue_stall_o = w_hazard;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Self-checking bench for wb_port_arbiter: directed scenarios
//               plus a randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int LIMIT = 4;
  localparam int MAXO  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(
    .STARVE_LIMIT    (LIMIT),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  bit [31:0] m_busy;
  int        m_out;
  int        m_refused;
  bit        m_hold;
  // Model expectations for the current cycle
  bit        e_stall, e_ready, e_grant, e_we;
  reg_addr_t e_wa;
  word_t     e_wd;

  task automatic model_reset();
    m_busy = '0; m_out = 0; m_refused = 0; m_hold = 1'b0;
  endtask

  task automatic model_eval();
    bit preq, haz;
    preq    = bus.pipe_we_i && (bus.pipe_wa_i != 5'd0);
    e_ready = !preq || m_hold;
    haz     = m_busy[bus.issue_rs_i] || m_busy[bus.issue_rt_i] || m_busy[bus.issue_rd_i] ||
              (bus.issue_long_i && m_out >= MAXO);
    e_stall = bus.issue_valid_i && haz;
    e_grant = bus.mdu_valid_i && e_ready;
    if (preq && !m_hold) begin
      e_we = 1'b1; e_wa = bus.pipe_wa_i; e_wd = bus.pipe_wd_i;
    end else if (e_grant && bus.mdu_wa_i != 5'd0) begin
      e_we = 1'b1; e_wa = bus.mdu_wa_i; e_wd = bus.mdu_wd_i;
    end else begin
      e_we = 1'b0; e_wa = '0; e_wd = '0;
    end
  endtask

  task automatic model_tick();
    if (e_grant) begin
      m_busy[bus.mdu_wa_i] = 1'b0;
      if (m_out > 0) m_out--;
    end
    if (bus.issue_valid_i && !e_stall && bus.issue_long_i) begin
      m_out++;
      if (bus.issue_rd_i != 5'd0) m_busy[bus.issue_rd_i] = 1'b1;
    end
    if (bus.mdu_valid_i && !e_grant) m_refused++;
    else m_refused = 0;
    m_hold = (m_refused == LIMIT);
  endtask

  task automatic idle_inputs();
    bus.issue_valid_i = 1'b0; bus.issue_long_i = 1'b0;
    bus.issue_rs_i = '0; bus.issue_rt_i = '0; bus.issue_rd_i = '0;
    bus.pipe_we_i = 1'b0; bus.pipe_wa_i = '0; bus.pipe_wd_i = '0;
    bus.mdu_valid_i = 1'b0; bus.mdu_wa_i = '0; bus.mdu_wd_i = '0;
  endtask

  task automatic set_issue(input bit v, input bit lng, input reg_addr_t rs, input reg_addr_t rt,
                           input reg_addr_t rd);
    bus.issue_valid_i = v; bus.issue_long_i = lng;
    bus.issue_rs_i = rs; bus.issue_rt_i = rt; bus.issue_rd_i = rd;
  endtask

  task automatic set_pipe(input bit we, input reg_addr_t wa, input word_t wd);
    bus.pipe_we_i = we; bus.pipe_wa_i = wa; bus.pipe_wd_i = wd;
  endtask

  task automatic set_mdu(input bit v, input reg_addr_t wa, input word_t wd);
    bus.mdu_valid_i = v; bus.mdu_wa_i = wa; bus.mdu_wd_i = wd;
  endtask

  // Evaluate the model on the freshly driven inputs, then move to the sample point
  task automatic settle();
    model_eval();
    @(negedge clk);
  endtask

  // Cross the active edge together with the model
  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    settle();
    vectors++; if (bus.issue_stall_o !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", bus.issue_stall_o); end
    vectors++; if (bus.we3_o !== 1'b0 || bus.wa3_o !== 5'd0 || bus.wd3_o !== 32'd0) begin miscompares++; $display("FAIL reset_port: got we=%b wa=%0d wd=%h want 0/0/0", bus.we3_o, bus.wa3_o, bus.wd3_o); end
    vectors++; if (bus.pipe_hold_o !== 1'b0) begin miscompares++; $display("FAIL reset_hold: got %b want 0", bus.pipe_hold_o); end
    vectors++; if (bus.mdu_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", bus.mdu_ready_o); end
    tick();
    set_issue(1, 1, 5'd5, 5'd6, 5'd7);
    settle();
    vectors++; if (bus.issue_stall_o !== 1'b0) begin miscompares++; $display("FAIL reset_long_issue: got %b want 0", bus.issue_stall_o); end
    tick();
  endtask

  task automatic test_long_issue();
    reset_dut();
    set_issue(1, 1, 5'd1, 5'd2, 5'd5);
    settle();
    vectors++; if (bus.issue_stall_o !== 1'b0) begin miscompares++; $display("FAIL li_accept: got %b want 0", bus.issue_stall_o); end
    tick();
    set_issue(1, 0, 5'd5, 5'd0, 5'd6);
    for (int c = 0; c < 2; c++) begin
      settle();
      vectors++; if (bus.issue_stall_o !== 1'b1) begin miscompares++; $display("FAIL li_raw_stall: got %b want 1", bus.issue_stall_o); end
      tick();
    end
    set_mdu(1, 5'd5, 32'h1234_5678);
    settle();
    vectors++; if (bus.issue_stall_o !== 1'b1) begin miscompares++; $display("FAIL li_grant_cycle_stall: got %b want 1", bus.issue_stall_o); end
    vectors++; if (bus.we3_o !== 1'b1 || bus.wa3_o !== 5'd5 || bus.wd3_o !== 32'h1234_5678) begin miscompares++; $display("FAIL li_mdu_write: got we=%b wa=%0d wd=%h want 1/5/12345678", bus.we3_o, bus.wa3_o, bus.wd3_o); end
    tick();
    set_mdu(0, 5'd0, 32'd0);
    settle();
    vectors++; if (bus.issue_stall_o !== 1'b0) begin miscompares++; $display("FAIL li_released: got %b want 0", bus.issue_stall_o); end
    tick();
  endtask

  task automatic test_simultaneous();
    reset_dut();
    set_issue(1, 1, 5'd0, 5'd0, 5'd7);
    tick();
    set_issue(0, 0, 5'd0, 5'd0, 5'd0);
    set_pipe(1, 5'd3, 32'h0000_AAAA);
    set_mdu(1, 5'd7, 32'h0000_BBBB);
    settle();
    vectors++; if (bus.we3_o !== 1'b1 || bus.wa3_o !== 5'd3 || bus.wd3_o !== 32'h0000_AAAA) begin miscompares++; $display("FAIL sim_pipe_wins: got we=%b wa=%0d wd=%h want 1/3/0000aaaa", bus.we3_o, bus.wa3_o, bus.wd3_o); end
    vectors++; if (bus.mdu_ready_o !== 1'b0) begin miscompares++; $display("FAIL sim_mdu_refused: got %b want 0", bus.mdu_ready_o); end
    tick();
    set_pipe(0, 5'd0, 32'd0);
    settle();
    vectors++; if (bus.we3_o !== 1'b1 || bus.wa3_o !== 5'd7 || bus.wd3_o !== 32'h0000_BBBB || bus.mdu_ready_o !== 1'b1) begin miscompares++; $display("FAIL sim_mdu_commit: got we=%b wa=%0d wd=%h rdy=%b want 1/7/0000bbbb/1", bus.we3_o, bus.wa3_o, bus.wd3_o, bus.mdu_ready_o); end
    tick();
  endtask

  task automatic test_starvation();
    reset_dut();
    set_issue(1, 1, 5'd0, 5'd0, 5'd9);
    tick();
    set_issue(0, 0, 5'd0, 5'd0, 5'd0);
    set_mdu(1, 5'd9, 32'h0000_9999);
    for (int c = 1; c <= LIMIT; c++) begin
      set_pipe(1, 5'd3, 32'(c));
      settle();
      vectors++; if (bus.pipe_hold_o !== 1'b0 || bus.mdu_ready_o !== 1'b0 || bus.wa3_o !== 5'd3) begin miscompares++; $display("FAIL starve_wait%0d: got hold=%b rdy=%b wa=%0d want 0/0/3", c, bus.pipe_hold_o, bus.mdu_ready_o, bus.wa3_o); end
      tick();
    end
    set_pipe(1, 5'd3, 32'h0000_0055);
    settle();
    vectors++; if (bus.pipe_hold_o !== 1'b1 || bus.mdu_ready_o !== 1'b1) begin miscompares++; $display("FAIL starve_hold: got hold=%b rdy=%b want 1/1", bus.pipe_hold_o, bus.mdu_ready_o); end
    vectors++; if (bus.we3_o !== 1'b1 || bus.wa3_o !== 5'd9 || bus.wd3_o !== 32'h0000_9999) begin miscompares++; $display("FAIL starve_mdu_write: got we=%b wa=%0d wd=%h want 1/9/00009999", bus.we3_o, bus.wa3_o, bus.wd3_o); end
    tick();
    set_mdu(0, 5'd0, 32'd0);
    settle();
    vectors++; if (bus.pipe_hold_o !== 1'b0 || bus.we3_o !== 1'b1 || bus.wa3_o !== 5'd3 || bus.wd3_o !== 32'h0000_0055) begin miscompares++; $display("FAIL starve_pipe_lands: got hold=%b we=%b wa=%0d wd=%h want 0/1/3/00000055", bus.pipe_hold_o, bus.we3_o, bus.wa3_o, bus.wd3_o); end
    tick();
  endtask

  task automatic test_outstanding_limit();
    reset_dut();
    for (int i = 0; i < MAXO; i++) begin
      set_issue(1, 1, 5'd0, 5'd0, 5'(10 + i));
      settle();
      vectors++; if (bus.issue_stall_o !== 1'b0) begin miscompares++; $display("FAIL lim_accept%0d: got %b want 0", i, bus.issue_stall_o); end
      tick();
    end
    set_issue(1, 1, 5'd0, 5'd0, 5'd14);
    settle();
    vectors++; if (bus.issue_stall_o !== 1'b1) begin miscompares++; $display("FAIL lim_full_stall: got %b want 1", bus.issue_stall_o); end
    tick();
    set_issue(1, 0, 5'd1, 5'd2, 5'd15);
    settle();
    vectors++; if (bus.issue_stall_o !== 1'b0) begin miscompares++; $display("FAIL lim_short_ok: got %b want 0", bus.issue_stall_o); end
    tick();
    set_issue(1, 1, 5'd0, 5'd0, 5'd14);
    set_mdu(1, 5'd10, 32'h0000_0A0A);
    settle();
    vectors++; if (bus.issue_stall_o !== 1'b1 || bus.wa3_o !== 5'd10) begin miscompares++; $display("FAIL lim_grant_cycle: got stall=%b wa=%0d want 1/10", bus.issue_stall_o, bus.wa3_o); end
    tick();
    set_mdu(0, 5'd0, 32'd0);
    settle();
    vectors++; if (bus.issue_stall_o !== 1'b0) begin miscompares++; $display("FAIL lim_released: got %b want 0", bus.issue_stall_o); end
    tick();
  endtask

  task automatic test_reg_zero();
    reset_dut();
    set_issue(1, 1, 5'd0, 5'd0, 5'd0);
    settle();
    vectors++; if (bus.issue_stall_o !== 1'b0) begin miscompares++; $display("FAIL r0_long_accept: got %b want 0", bus.issue_stall_o); end
    tick();
    set_issue(1, 0, 5'd0, 5'd0, 5'd0);
    settle();
    vectors++; if (bus.issue_stall_o !== 1'b0) begin miscompares++; $display("FAIL r0_not_busy: got %b want 0", bus.issue_stall_o); end
    tick();
    for (int i = 1; i <= 3; i++) begin
      set_issue(1, 1, 5'd0, 5'd0, 5'(i));
      tick();
    end
    set_issue(1, 1, 5'd0, 5'd0, 5'd4);
    settle();
    vectors++; if (bus.issue_stall_o !== 1'b1) begin miscompares++; $display("FAIL r0_counted: got %b want 1", bus.issue_stall_o); end
    tick();
    set_issue(0, 0, 5'd0, 5'd0, 5'd0);
    set_mdu(1, 5'd0, 32'h0000_0055);
    settle();
    vectors++; if (bus.we3_o !== 1'b0 || bus.mdu_ready_o !== 1'b1) begin miscompares++; $display("FAIL r0_mdu_drop: got we=%b rdy=%b want 0/1", bus.we3_o, bus.mdu_ready_o); end
    tick();
    set_pipe(1, 5'd0, 32'h0000_0066);
    set_mdu(1, 5'd1, 32'h0000_0077);
    settle();
    vectors++; if (bus.mdu_ready_o !== 1'b1 || bus.we3_o !== 1'b1 || bus.wa3_o !== 5'd1 || bus.wd3_o !== 32'h0000_0077) begin miscompares++; $display("FAIL r0_pipe_ignored: got rdy=%b we=%b wa=%0d wd=%h want 1/1/1/00000077", bus.mdu_ready_o, bus.we3_o, bus.wa3_o, bus.wd3_o); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    reset_dut();
    for (int i = 1; i <= 3; i++) begin
      set_issue(1, 1, 5'd0, 5'd0, 5'(i));
      tick();
    end
    set_issue(0, 0, 5'd0, 5'd0, 5'd0);
    set_pipe(1, 5'd20, 32'h0000_2020);
    set_mdu(1, 5'd1, 32'h0000_1111);
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    set_issue(1, 0, 5'd2, 5'd3, 5'd1);
    #1;
    vectors++; if (bus.pipe_hold_o !== 1'b0 || bus.issue_stall_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_clear: got hold=%b stall=%b want 0/0", bus.pipe_hold_o, bus.issue_stall_o); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_issue(1, 1, 5'd0, 5'd0, 5'd1);
    settle();
    vectors++; if (bus.issue_stall_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_issue: got %b want 0", bus.issue_stall_o); end
    tick();
    set_issue(0, 0, 5'd0, 5'd0, 5'd0);
    for (int c = 2; c <= LIMIT; c++) begin
      settle();
      vectors++; if (bus.pipe_hold_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_wait%0d: got hold=%b want 0", c, bus.pipe_hold_o); end
      tick();
    end
    settle();
    vectors++; if (bus.pipe_hold_o !== 1'b1 || bus.mdu_ready_o !== 1'b1) begin miscompares++; $display("FAIL rst_mid_fresh_hold: got hold=%b rdy=%b want 1/1", bus.pipe_hold_o, bus.mdu_ready_o); end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    reg_addr_t pend[$];
    bit        presenting;
    reg_addr_t cur_wa;
    reset_dut();
    presenting = 1'b0;
    cur_wa     = '0;
    for (int n = 0; n < 400; n++) begin
      if (!presenting && pend.size() > 0 && ($urandom_range(0, 2) == 0)) begin
        cur_wa     = pend.pop_front();
        presenting = 1'b1;
        set_mdu(1, cur_wa, $urandom);
      end else if (!presenting) begin
        set_mdu(0, 5'd0, 32'd0);
      end
      set_pipe(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 7)), $urandom);
      set_issue($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      settle();
      vectors++; if (bus.issue_stall_o !== e_stall) begin miscompares++; $display("FAIL rnd_stall@%0d: got %b want %b", n, bus.issue_stall_o, e_stall); end
      vectors++; if (bus.mdu_ready_o !== e_ready) begin miscompares++; $display("FAIL rnd_ready@%0d: got %b want %b", n, bus.mdu_ready_o, e_ready); end
      vectors++; if (bus.pipe_hold_o !== m_hold) begin miscompares++; $display("FAIL rnd_hold@%0d: got %b want %b", n, bus.pipe_hold_o, m_hold); end
      vectors++; if (bus.we3_o !== e_we || bus.wa3_o !== e_wa || bus.wd3_o !== e_wd) begin miscompares++; $display("FAIL rnd_port@%0d: got we=%b wa=%0d wd=%h want %b/%0d/%h", n, bus.we3_o, bus.wa3_o, bus.wd3_o, e_we, e_wa, e_wd); end
      if (bus.issue_valid_i && !e_stall && bus.issue_long_i) pend.push_back(bus.issue_rd_i);
      if (e_grant) presenting = 1'b0;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_long_issue();
    test_simultaneous();
    test_starvation();
    test_outstanding_limit();
    test_reg_zero();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
